// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and the modulo-DEPTH pointer step for the FIFO controller.
// Optional build macro used by the top: FIFO_CTRL_ERR_FLAGS_EN.
package fifo_ctrl_pkg;

    localparam int DEF_DEPTH  = 90;
    localparam int DEF_PW     = 8;
    localparam int DEF_CW     = 8;
    localparam int DEF_AF_THR = 80;
    localparam int DEF_AE_THR = 8;

    // Wraps at depth-1, so non-power-of-two depths never touch unused slots
    function automatic int next_ptr(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_mod_ptr_cnt.sv
// Modulo-DEPTH pointer register with enable; async active-low reset to 0.
// Used once for the write pointer and once for the read pointer.
module mod_ptr_cnt
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int PW    = DEF_PW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [PW-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (en)
            ptr <= PW'(next_ptr(int'(ptr), DEPTH));
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Pointer/occupancy controller for a single-clock FIFO memory with 1-cycle read.
// Define FIFO_CTRL_ERR_FLAGS_EN to add sticky overflow/underflow flags and err_clr.
module fifo_ptr_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int PW     = DEF_PW,
    parameter int CW     = DEF_CW,
    parameter int AF_THR = DEF_AF_THR,
    parameter int AE_THR = DEF_AE_THR
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    input  logic          err_clr,
    output logic          overflow,
    output logic          underflow,
`endif
    input  logic          wr_req,
    input  logic          rd_req,
    output logic [PW-1:0] wrPtr,
    output logic [PW-1:0] rdPtr,
    output logic          wren,
    output logic          rden,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [CW-1:0] count,
    output logic          rd_valid
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Flags decode only the count register, so they never glitch on requests
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_THR));
    assign almost_empty = (count_q <= CW'(AE_THR));
    assign count        = count_q;

    assign wren = wr_req & ~full;
    assign rden = rd_req & ~empty;

    mod_ptr_cnt #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (wren),
        .ptr   (wrPtr)
    );

    mod_ptr_cnt #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rden),
        .ptr   (rdPtr)
    );

    always_comb begin
        count_d = count_q;
        unique case ({wren, rden})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            rd_valid <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_valid <= rden;
        end
    end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    // A new error in the clear cycle wins over err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_req & full) | (overflow & ~err_clr);
            underflow <= (rd_req & empty) | (underflow & ~err_clr);
        end
    end
`endif

endmodule

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
Single-clock controller that sequences the FIFO memory block (byte-wide storage, registered read port, separate write/read pointer and enable inputs).
- Accepts write/read requests from producer and consumer.
- Generates the memory's pointers and enables.
- Tracks occupancy, raises full/empty/almost flags and aligns a read-valid strobe with the memory's one-cycle read latency.
- Both memory clock inputs are tied to this block's clk.

Parameters:
- DEPTH, 90, number of memory entries; any value 2..255, not required to be a power of two.
- PW, 8, pointer width; must match memory pointer width, DEPTH <= 2^PW.
- CW, 8, occupancy count width; must hold DEPTH.
- AF_THR, 80, almost_full asserted when count >= AF_THR.
- AE_THR, 8, almost_empty asserted when count <= AE_THR.

Ports:
- clk  input  1  single clock; also drives both memory clocks.
- rst_n  input  1  asynchronous, active-low reset.
- wr_req  input  1  producer write request.
- rd_req  input  1  consumer read request.
- wrPtr  output  PW  write pointer to memory.
- rdPtr  output  PW  read pointer to memory.
- wren  output  1  memory write enable.
- rden  output  1  memory read enable.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THR.
- almost_empty  output  1  count <= AE_THR.
- count  output  CW  current occupancy.
- rd_valid  output  1  memory read data valid this cycle.

Behaviour:
- Reset (async assert, sync release): wrPtr=0, rdPtr=0, count=0, rd_valid=0. Flags follow: empty=1, full=0, almost_empty=1, almost_full=0.
- Enables are combinational: wren = wr_req & ~full; rden = rd_req & ~empty.
- Flags are combinational decodes of the count register only, so they are glitch-free and settle one cycle after the causing edge.
- On a clk edge with wren=1: wrPtr <= (wrPtr==DEPTH-1) ? 0 : wrPtr+1.
- On a clk edge with rden=1: rdPtr wraps the same way.
- Wrap is modulo DEPTH, never modulo 2^PW.
- count update:
  - +1 on wren only.
  - -1 on rden only.
  - Unchanged when both or neither are set.
- Full plus simultaneous wr_req/rd_req: read accepted, write rejected. Result: count becomes DEPTH-1, full deasserts next cycle.
- Empty plus simultaneous requests: write accepted, read rejected, no bypass. Result: count becomes 1.
- Write request while full: dropped, wren=0, pointers and count unchanged.
- Read request while empty: same rule.
- rd_valid <= rden, i.e. one-cycle latency, matching the memory's registered rdData.
- Reset mid-operation: all state clears immediately. rd_valid drops even if a read was in flight. Memory contents are not cleared and are treated as stale.

Optional Feature:
Macro FIFO_CTRL_ERR_FLAGS_EN.
- Defined:
  - Adds input err_clr and outputs overflow and underflow.
  - overflow sets when wr_req & full; underflow sets when rd_req & empty.
  - Both flags are sticky until an err_clr cycle.
  - If err_clr and a new error occur in the same cycle, the set wins.
  - Both reset to 0.
- Undefined: these ports and that logic are absent. Dropped requests are silent.

Decomposition:
- Package fifo_ctrl_pkg:
  - Default DEPTH, AF_THR and AE_THR constants.
  - Pointer and count width constants.
  - Function next_ptr(ptr, depth) for modulo-DEPTH increment.
- Sub-module mod_ptr_cnt: modulo-DEPTH pointer register with enable, async reset to 0. Instantiated twice, once for the write pointer and once for the read pointer.

Test Plan:
- Reset, then 90 consecutive writes:
  - wrPtr steps 0..89 then 0.
  - full=1 and count=90 the cycle after the 90th write.
  - almost_full first seen at count=80.
  - A 91st wr_req gives wren=0 and no state change.
- From empty, rd_req for 3 cycles: rden=0, rd_valid=0, rdPtr=0, count=0. With FIFO_CTRL_ERR_FLAGS_EN, underflow=1 until err_clr.
- Full FIFO, one cycle of wr_req=rd_req=1: rden=1, wren=0, count=89, rdPtr=1, rd_valid=1 the next cycle.
- Empty FIFO, wr_req=rd_req=1: wren=1, rden=0, count=1, empty=0 the next cycle.
- Streaming: 200 cycles of simultaneous read/write after 10 pre-writes.
  - count stays at 10.
  - Both pointers wrap at 89 to 0.
  - Data read back matches write order through the memory block.
- rst_n asserted mid-stream at count=45: all outputs return to reset values asynchronously. After release the first write lands at wrPtr=0.
